// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access and writeback stage of the 3-stage RV32I pipeline
//
// Registers the execute-stage result and control, drives the data-memory port
// for loads/stores, extracts load data and produces the register-file write.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   ex_*                           instruction arriving from execute
//   stall                          freezes fetch/execute while a load is waiting
//   dmem_req/we/addr/wdata/be      data-memory request (one strobe per access)
//   dmem_rvalid/rdata              data-memory load response
//   rf_we/waddr/wdata              register-file write (also the forwarding source)
//   misalign_exc, bus_err          one-cycle exception pulses
module mem_wb_stage #(
  parameter int TIMEOUT_CYC = 16,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_we,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [2:0]        ex_funct3,
  input  logic              ex_flush,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              misalign_exc,
  output logic              bus_err
);

  typedef enum logic {RUN, LOAD_WAIT} state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic              valid_q, we_q, mem_rd_q, mem_wr_q;
  logic [DATA_W-1:0] alu_q, sdata_q;
  logic [4:0]        rd_q;
  logic [2:0]        f3_q;

  logic [1:0]        a;
  logic              mem_acc, misaligned, issue, ld_issue, in_wait, ld_done, timeout_hit;
  logic              wb_en;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;

  assign a = alu_q[1:0];

  always_comb begin
    mem_acc     = valid_q & (mem_rd_q | mem_wr_q);
    misaligned  = ((f3_q[1:0] == 2'b01) & a[0]) | ((f3_q[1:0] == 2'b10) & (a != 2'b00));
    issue       = (state == RUN) & mem_acc & ~misaligned;
    ld_issue    = issue & mem_rd_q;
    in_wait     = (state == LOAD_WAIT);
    ld_done     = (ld_issue | in_wait) & dmem_rvalid;
    timeout_hit = in_wait & ~dmem_rvalid & (cnt == 8'(TIMEOUT_CYC - 1));
    // A load that has not completed this cycle holds the upstream stages.
    stall       = (ld_issue & ~dmem_rvalid) | (in_wait & ~dmem_rvalid & ~timeout_hit);
  end

  always_comb begin
    case (a)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    dmem_req   = issue;
    dmem_we    = issue & mem_wr_q;
    dmem_addr  = issue ? {alu_q[DATA_W-1:2], 2'b00} : '0;
    dmem_be    = 4'b0000;
    dmem_wdata = '0;
    if (issue && mem_wr_q) begin
      case (f3_q[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << a;
          dmem_wdata = {4{sdata_q[7:0]}};
        end
        2'b01: begin
          dmem_be    = a[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{sdata_q[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = sdata_q;
        end
      endcase
    end else if (issue) begin
      dmem_be = 4'b1111;
    end

    if (mem_rd_q)
      wb_en = ld_done & we_q & (rd_q != 5'd0);
    else
      wb_en = valid_q & we_q & ~mem_wr_q & (rd_q != 5'd0);
    rf_we    = wb_en;
    rf_waddr = wb_en ? rd_q : 5'd0;
    rf_wdata = wb_en ? (mem_rd_q ? ld_data : alu_q) : '0;

    misalign_exc = (state == RUN) & mem_acc & misaligned;
    bus_err      = timeout_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      alu_q    <= '0;
      sdata_q  <= '0;
      rd_q     <= 5'd0;
      we_q     <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      f3_q     <= 3'd0;
      state    <= RUN;
      cnt      <= 8'd0;
    end else begin
      // Flush is only honoured on capture; a held instruction is older than the flushed one.
      if (!stall) begin
        valid_q  <= ex_valid & ~ex_flush;
        alu_q    <= ex_alu_result;
        sdata_q  <= ex_store_data;
        rd_q     <= ex_rd;
        we_q     <= ex_reg_we;
        mem_rd_q <= ex_mem_rd;
        mem_wr_q <= ex_mem_wr;
        f3_q     <= ex_funct3;
      end
      case (state)
        RUN: begin
          cnt <= 8'd0;
          if (ld_issue && !dmem_rvalid) state <= LOAD_WAIT;
        end
        default: begin
          cnt <= cnt + 8'd1;
          if (dmem_rvalid || timeout_hit) begin
            state <= RUN;
            cnt   <= 8'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard testbench for mem_wb_stage
module tb_mem_wb_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_we = 1'b0;
  logic        ex_mem_rd = 1'b0;
  logic        ex_mem_wr = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_flush = 1'b0;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_exc, bus_err;

  mem_wb_stage #(.TIMEOUT_CYC(TO), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_funct3(ex_funct3), .ex_flush(ex_flush), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [36:0] wb_q[$];   // {rd, data}
  logic [68:0] req_q[$];  // {we, addr, be, wdata}
  logic [1:0]  evt_q[$];  // 1 = misalign, 2 = bus error

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_we) begin
        if (wb_q.size() == 0) check("unexpected_rf_we", {32'd0, rf_waddr, rf_wdata}, 69'd0);
        else check("writeback", {32'd0, rf_waddr, rf_wdata}, {32'd0, wb_q.pop_front()});
      end else if (rf_wdata !== 32'd0) begin
        check("rf_wdata_idle_zero", {37'd0, rf_wdata}, 69'd0);
      end
      if (dmem_req) begin
        if (req_q.size() == 0) check("unexpected_dmem_req", {dmem_we, dmem_addr, dmem_be, dmem_wdata}, 69'd0);
        else check("dmem_req", {dmem_we, dmem_addr, dmem_be, dmem_wdata}, req_q.pop_front());
      end
      if (misalign_exc || bus_err) begin
        if (evt_q.size() == 0) check("unexpected_exception", {67'd0, bus_err, misalign_exc}, 69'd0);
        else check("exception", {67'd0, bus_err, misalign_exc}, {67'd0, evt_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for a single capture edge, then a bubble.
  task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                       input logic we, input logic lr, input logic sw, input logic [2:0] f3,
                       input logic fl);
    ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
    ex_reg_we = we; ex_mem_rd = lr; ex_mem_wr = sw; ex_funct3 = f3; ex_flush = fl;
    step();
    ex_valid = 1'b0; ex_flush = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_reg_we = 1'b0;
  endtask

  // Called one step after issue (in the request cycle); returns the stalled cycles.
  task automatic run_load(input int delay, input logic [31:0] rdata, output int nstall);
    nstall = 0;
    dmem_rdata = rdata;
    for (int k = 0; k < 60; k++) begin
      dmem_rvalid = (k == delay);
      #3;
      if (stall) nstall++;
      else break;
      step();
    end
    step();
    dmem_rvalid = 1'b0;
  endtask

  int ns;

  initial begin
    #2;
    check("reset_outputs", {52'd0, stall, dmem_req, dmem_we, dmem_be, rf_we, misalign_exc, bus_err, rf_waddr, 4'd0},
          69'd0);
    check("reset_data", {5'd0, dmem_addr, rf_wdata}, 69'd0);
    step(); rst_n = 1'b1; step();

    // 1: ALU op writeback, then rd=0 suppressed
    wb_q.push_back({5'd5, 32'h0000_1234});
    issue(32'h1234, 0, 5'd5, 1, 0, 0, 3'b000, 0);
    issue(32'h5678, 0, 5'd0, 1, 0, 0, 3'b000, 0);
    step();

    // 2: stores SB / SH / SW
    req_q.push_back({1'b1, 32'h100, 4'b1000, 32'hABAB_ABAB});
    issue(32'h103, 32'h0000_00AB, 5'd7, 0, 0, 1, 3'b000, 0);
    req_q.push_back({1'b1, 32'h100, 4'b1100, 32'hCDEF_CDEF});
    issue(32'h102, 32'h1234_CDEF, 5'd7, 0, 0, 1, 3'b001, 0);
    req_q.push_back({1'b1, 32'h104, 4'b1111, 32'hDEAD_BEEF});
    issue(32'h104, 32'hDEAD_BEEF, 5'd7, 0, 0, 1, 3'b010, 0);
    step();

    // 3: LB / LBU with rvalid three cycles after request; zero-wait LH
    req_q.push_back({1'b0, 32'h100, 4'b1111, 32'd0});
    wb_q.push_back({5'd9, 32'hFFFF_FF80});
    issue(32'h102, 0, 5'd9, 1, 1, 0, 3'b000, 0);
    run_load(3, 32'h0080_0000, ns);
    check("lb_stall_cycles", 69'(ns), 69'd3);
    req_q.push_back({1'b0, 32'h100, 4'b1111, 32'd0});
    wb_q.push_back({5'd9, 32'h0000_0080});
    issue(32'h102, 0, 5'd9, 1, 1, 0, 3'b100, 0);
    run_load(3, 32'h0080_0000, ns);
    check("lbu_stall_cycles", 69'(ns), 69'd3);
    req_q.push_back({1'b0, 32'h100, 4'b1111, 32'd0});
    wb_q.push_back({5'd10, 32'hFFFF_8001});
    issue(32'h102, 0, 5'd10, 1, 1, 0, 3'b001, 0);
    run_load(0, 32'h8001_0000, ns);
    check("lh_zero_wait_stall", 69'(ns), 69'd0);

    // 4: misaligned LW and SH
    evt_q.push_back(2'b01);
    issue(32'h102, 0, 5'd11, 1, 1, 0, 3'b010, 0);
    #3 check("misalign_no_stall", {68'd0, stall}, 69'd0);
    evt_q.push_back(2'b01);
    issue(32'h101, 32'h55, 5'd0, 0, 0, 1, 3'b001, 0);
    step();

    // 5: load timeout, then a late rvalid must not write
    req_q.push_back({1'b0, 32'h200, 4'b1111, 32'd0});
    evt_q.push_back(2'b10);
    issue(32'h200, 0, 5'd12, 1, 1, 0, 3'b010, 0);
    run_load(1000, 32'h1111_1111, ns);
    check("timeout_stall_cycles", 69'(ns), 69'(TO));
    dmem_rvalid = 1'b1; step(); dmem_rvalid = 1'b0;
    step();

    // 6: reset during LOAD_WAIT, then flushed instruction
    req_q.push_back({1'b0, 32'h300, 4'b1111, 32'd0});
    issue(32'h300, 0, 5'd13, 1, 1, 0, 3'b010, 0);
    step(); step();
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {52'd0, stall, dmem_req, dmem_we, dmem_be, rf_we, misalign_exc, bus_err, rf_waddr, 4'd0},
          69'd0);
    check("async_reset_data", {5'd0, dmem_addr, rf_wdata}, 69'd0);
    step(); rst_n = 1'b1; step();
    issue(32'h400, 32'h1, 5'd14, 1, 0, 1, 3'b010, 1);
    issue(32'h404, 0, 5'd15, 1, 0, 0, 3'b000, 1);
    step(); step();

    check("wb_queue_drained", 69'(wb_q.size()), 69'd0);
    check("req_queue_drained", 69'(req_q.size()), 69'd0);
    check("evt_queue_drained", 69'(evt_q.size()), 69'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
